ifetch_mem_arbiter: RTL and testbench
=====================================

Name: ifetch_mem_arbiter

Overview:
- Shares one single-ported synchronous RAM (1-cycle read latency) between the instruction-fetch requester and the data-access requester.
- Grants at most one request per cycle and steers the RAM read data back to the owner one cycle later.
- Fixed data-over-instruction priority, with a starvation guard that forces an instruction grant.
- Honours instruction-flush cancel so that a fetch on a mispredicted path never returns data.

Parameters:
- ADDR_W, 32, address width for both requesters and the RAM.
- DATA_W, 32, data width; byte enables are DATA_W/8 wide.
- MAX_WAIT, 3, number of consecutive cycles a pending instruction request may lose before it is forced to win; legal range 1..15.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- inst_req_valid  in  1  fetch request pending.
- inst_req_addr  in  ADDR_W  fetch address.
- inst_req_ready  out  1  fetch granted this cycle.
- inst_cancel  in  1  flush; kills an in-flight or granted fetch.
- inst_rsp_valid  out  1  fetch data valid.
- inst_rsp_data  out  DATA_W  fetched instruction.
- data_req_valid  in  1  data request pending.
- data_req_w_en  in  DATA_W/8  byte write enables; all zero means read.
- data_req_addr  in  ADDR_W  data address.
- data_req_w_data  in  DATA_W  store data.
- data_req_ready  out  1  data request granted this cycle.
- data_rsp_valid  out  1  load data valid.
- data_rsp_data  out  DATA_W  load data.
- ram_en  out  1  RAM enable.
- ram_w_en  out  DATA_W/8  RAM byte write enables.
- ram_addr  out  ADDR_W  RAM address.
- ram_w_data  out  DATA_W  RAM write data.
- ram_r_data  in  DATA_W  RAM read data; valid the cycle after a read enable.

Behaviour:
- Grant is combinational from the current-cycle requests and the registered state. A handshake occurs when valid and ready are both high in the same cycle.
- Request values must remain stable while valid is high and ready is low.
- Arbitration:
  - Only data valid: grant data.
  - Only inst valid: grant inst.
  - Both valid: grant data, unless wait_cnt == MAX_WAIT, in which case grant inst.
- wait_cnt, 4 bits:
  - Increments each cycle inst_req_valid is high and not granted.
  - Clears on an inst grant, or on any cycle inst_req_valid is low.
  - Saturates at MAX_WAIT.
- RAM drive:
  - No grant: ram_en=0, ram_w_en=0, ram_addr=0, ram_w_data=0.
  - Inst grant: ram_en=1, ram_w_en=0, ram_addr=inst_req_addr.
  - Data grant: ram_en=1, ram_w_en=data_req_w_en, ram_addr=data_req_addr, ram_w_data=data_req_w_data.
- Owner register (2-bit state), updated every cycle:
  - OWN_NONE: no grant, or a data write granted.
  - OWN_INST: inst granted and inst_cancel low.
  - OWN_DATA: data read granted.
- Responses, fixed 1-cycle latency, no backpressure (requesters must accept):
  - inst_rsp_valid = (owner==OWN_INST) & ~inst_cancel.
  - data_rsp_valid = (owner==OWN_DATA).
  - Both rsp_data outputs equal ram_r_data when their valid is high, otherwise 0.
- Writes complete at grant; they produce no response.
- Cancel:
  - inst_cancel in the grant cycle: the RAM read still occurs, owner becomes OWN_NONE, no response.
  - inst_cancel in the response cycle: inst_rsp_valid is forced low.
  - inst_cancel never blocks data grants. It does not clear wait_cnt unless inst_req_valid is also low.
- Simultaneous events:
  - Data write granted while an inst response returns: both happen; the response uses the previous cycle's read data.
  - Back-to-back grants are supported; one grant per cycle for full throughput.
- Reset (any cycle, including with a response in flight):
  - owner=OWN_NONE, wait_cnt=0, and, with ARB_RR_EN defined, last_grant=inst.
  - All outputs are 0 in the reset cycle. ram_en=0 while reset is high, even if requests are valid.
  - A response pending at reset is dropped.

Optional Feature:
- Macro: ARB_RR_EN.
- Defined: fixed priority and wait_cnt are removed (wait_cnt tied 0).
  - A 1-bit last_grant register gives priority, on contention, to the requester that did not win the most recent grant.
  - last_grant updates on every grant. Reset value is inst, so data wins the first contention.
- Undefined: fixed data priority with the MAX_WAIT starvation guard, as described in Behaviour.

Test Plan:
- Reset with both requests valid (inst addr 0x1c000000, data read 0x100) → no ram_en and all responses low during reset. The first cycle after reset grants data, and data_rsp_valid rises 1 cycle later with ram_r_data.
- Inst only, addr 0x1c000000 then 0x1c000004 on consecutive cycles → inst_req_ready=1 both cycles. inst_rsp_valid=1 in cycles 2 and 3 with RAM contents in order.
- Both valid continuously, MAX_WAIT=3 → grant pattern D,D,D,I,D,D,D,I. wait_cnt clears after each inst grant.
- Inst grant at 0x1c000010, inst_cancel=1 in the following cycle → inst_rsp_valid stays 0. A data read granted in that same cycle returns normally.
- Data store w_en=4'b0011, addr 0x200, wdata 0xdeadbeef, with inst idle → ram_w_en=0011 for one cycle and no data_rsp_valid. A subsequent load of 0x200 returns the stored halfword.
- With ARB_RR_EN defined, both valid continuously → grants alternate D,I,D,I starting with D after reset.

Source files
------------

// File: rtl/ifetch_mem_arbiter.sv
// ifetch_mem_arbiter
//   Lets the instruction-fetch requester and the data-access requester share
//   one single-ported synchronous RAM with a 1-cycle read latency. At most one
//   request is granted per cycle. The RAM read data is steered back to the
//   request's owner on the following cycle.
//
//   Default arbitration: data has fixed priority over inst. A starvation
//   guard forces an inst grant once a pending fetch has lost MAX_WAIT
//   consecutive cycles.
//   Optional macro ARB_RR_EN: replaces that scheme with round-robin between
//   the two requesters. On contention, the requester that did not win the
//   most recent grant wins.
//
//   inst_cancel (flush) in the grant cycle or the response cycle suppresses
//   the fetch response. A fetch on a mispredicted path therefore never
//   returns data.
//
// Ports
//   clk, reset        clock, synchronous active-high reset
//   inst_req_*        fetch request (valid/addr) and grant (ready)
//   inst_cancel       flush of an in-flight or currently granted fetch
//   inst_rsp_*        fetch response, 1 cycle after grant, no backpressure
//   data_req_*        load/store request; w_en == 0 means load
//   data_rsp_*        load response, 1 cycle after grant; stores give none
//   ram_*             single-port RAM command and read data
//
// Parameters
//   ADDR_W    address width (both requesters and the RAM)
//   DATA_W    data width; byte enables are DATA_W/8 wide
//   MAX_WAIT  cycles a pending fetch may lose before it is forced to win (1..15)

module ifetch_mem_arbiter #(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int MAX_WAIT = 3
) (
  input  logic                clk,
  input  logic                reset,

  input  logic                inst_req_valid,
  input  logic [ADDR_W-1:0]   inst_req_addr,
  output logic                inst_req_ready,
  input  logic                inst_cancel,
  output logic                inst_rsp_valid,
  output logic [DATA_W-1:0]   inst_rsp_data,

  input  logic                data_req_valid,
  input  logic [DATA_W/8-1:0] data_req_w_en,
  input  logic [ADDR_W-1:0]   data_req_addr,
  input  logic [DATA_W-1:0]   data_req_w_data,
  output logic                data_req_ready,
  output logic                data_rsp_valid,
  output logic [DATA_W-1:0]   data_rsp_data,

  output logic                ram_en,
  output logic [DATA_W/8-1:0] ram_w_en,
  output logic [ADDR_W-1:0]   ram_addr,
  output logic [DATA_W-1:0]   ram_w_data,
  input  logic [DATA_W-1:0]   ram_r_data
);

  localparam int BE_W = DATA_W / 8;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_INST = 2'd1,
    OWN_DATA = 2'd2
  } owner_e;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [BE_W-1:0]   w_en;
    logic [DATA_W-1:0] w_data;
  } ram_cmd_t;

  owner_e     owner;
  logic [3:0] wait_cnt;
  logic       inst_wins;    // inst takes the slot when both are valid
  logic       grant_inst;
  logic       grant_data;
  logic       data_is_rd;
  ram_cmd_t   cmd;

  assign data_is_rd = (data_req_w_en == '0);

  // ---------------------------------------------------------------------
  // Contention tie-break
  // ---------------------------------------------------------------------
`ifdef ARB_RR_EN
  localparam logic LG_INST = 1'b0;
  localparam logic LG_DATA = 1'b1;

  logic last_grant;

  // The loser of the most recent grant wins the next contention.
  assign inst_wins = (last_grant == LG_DATA);
  assign wait_cnt  = 4'd0;

  always_ff @(posedge clk) begin
    if (reset)           last_grant <= LG_INST;  // data wins first contention
    else if (grant_data) last_grant <= LG_DATA;
    else if (grant_inst) last_grant <= LG_INST;
  end
`else
  localparam logic [3:0] MAX_WAIT_C = 4'(MAX_WAIT);

  assign inst_wins = (wait_cnt == MAX_WAIT_C);

  // Counts consecutive lost cycles of a pending fetch. Cancel alone does not
  // clear it; only a grant or a dropped request does.
  always_ff @(posedge clk) begin
    if (reset)
      wait_cnt <= 4'd0;
    else if (!inst_req_valid || grant_inst)
      wait_cnt <= 4'd0;
    else if (wait_cnt < MAX_WAIT_C)
      wait_cnt <= wait_cnt + 4'd1;
  end
`endif

  // ---------------------------------------------------------------------
  // Grant: combinational from this cycle's requests and registered state.
  // Reset masks every grant, so the RAM stays idle even with requests valid.
  // ---------------------------------------------------------------------
  always_comb begin
    grant_inst = 1'b0;
    grant_data = 1'b0;
    if (!reset) begin
      if (inst_req_valid && data_req_valid) begin
        grant_inst = inst_wins;
        grant_data = !inst_wins;
      end else begin
        grant_inst = inst_req_valid;
        grant_data = data_req_valid;
      end
    end
  end

  assign inst_req_ready = grant_inst;
  assign data_req_ready = grant_data;

  // ---------------------------------------------------------------------
  // RAM command mux. An idle cycle drives all zeros. A fetch never writes.
  // ---------------------------------------------------------------------
  always_comb begin
    cmd = '0;
    if (grant_data) begin
      cmd.addr   = data_req_addr;
      cmd.w_en   = data_req_w_en;
      cmd.w_data = data_req_w_data;
    end else if (grant_inst) begin
      cmd.addr   = inst_req_addr;
    end
  end

  assign ram_en     = grant_inst | grant_data;
  assign ram_addr   = cmd.addr;
  assign ram_w_en   = cmd.w_en;
  assign ram_w_data = cmd.w_data;

  // ---------------------------------------------------------------------
  // Owner of next cycle's read data. A store completes at grant, so it
  // leaves no owner. A fetch cancelled in its grant cycle still reads the
  // RAM, but the data is discarded.
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset)
      owner <= OWN_NONE;
    else if (grant_inst && !inst_cancel)
      owner <= OWN_INST;
    else if (grant_data && data_is_rd)
      owner <= OWN_DATA;
    else
      owner <= OWN_NONE;
  end

  // ---------------------------------------------------------------------
  // Responses. A late cancel still kills a returning fetch. Reset drops
  // anything in flight and holds every output low.
  // ---------------------------------------------------------------------
  assign inst_rsp_valid = !reset && (owner == OWN_INST) && !inst_cancel;
  assign data_rsp_valid = !reset && (owner == OWN_DATA);
  assign inst_rsp_data  = inst_rsp_valid ? ram_r_data : '0;
  assign data_rsp_data  = data_rsp_valid ? ram_r_data : '0;

endmodule

// File: tb/tb_ifetch_mem_arbiter.sv
module tb_ifetch_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        inst_req_valid, inst_req_ready, inst_cancel, inst_rsp_valid;
  logic [31:0] inst_req_addr, inst_rsp_data;
  logic        data_req_valid, data_req_ready, data_rsp_valid;
  logic [3:0]  data_req_w_en;
  logic [31:0] data_req_addr, data_req_w_data, data_rsp_data;
  logic        ram_en;
  logic [3:0]  ram_w_en;
  logic [31:0] ram_addr, ram_w_data;
  logic [31:0] ram_r_data = '0;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  ifetch_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_WAIT(3)) dut (
    .clk(clk), .reset(reset),
    .inst_req_valid(inst_req_valid), .inst_req_addr(inst_req_addr),
    .inst_req_ready(inst_req_ready), .inst_cancel(inst_cancel),
    .inst_rsp_valid(inst_rsp_valid), .inst_rsp_data(inst_rsp_data),
    .data_req_valid(data_req_valid), .data_req_w_en(data_req_w_en),
    .data_req_addr(data_req_addr), .data_req_w_data(data_req_w_data),
    .data_req_ready(data_req_ready), .data_rsp_valid(data_rsp_valid),
    .data_rsp_data(data_rsp_data),
    .ram_en(ram_en), .ram_w_en(ram_w_en), .ram_addr(ram_addr),
    .ram_w_data(ram_w_data), .ram_r_data(ram_r_data)
  );

  // Behavioural single-port RAM with a 1-cycle read latency and byte writes.
  logic [31:0] mem [logic [31:0]];

  function automatic logic [31:0] rd(input logic [31:0] a);
    return mem.exists(a) ? mem[a] : 32'h0;
  endfunction

  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_w_en == 4'b0000) begin
        ram_r_data <= rd(ram_addr);
      end else begin
        logic [31:0] w;
        w = rd(ram_addr);
        for (int b = 0; b < 4; b++)
          if (ram_w_en[b]) w[b*8 +: 8] = ram_w_data[b*8 +: 8];
        mem[ram_addr] = w;
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
      else begin
        errors++;
        $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
  endtask

  // Inputs are changed just after a rising edge. Outputs are sampled on the
  // falling edge of the same cycle.
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic settle;
    @(negedge clk);
  endtask

  task automatic idle;
    inst_req_valid  = 1'b0; inst_req_addr = '0; inst_cancel = 1'b0;
    data_req_valid  = 1'b0; data_req_w_en = '0; data_req_addr = '0;
    data_req_w_data = '0;
  endtask

`ifdef ARB_RR_EN
  localparam logic [7:0] PAT = 8'b1010_1010;  // bit i: inst granted (D,I,D,I..)
`else
  localparam logic [7:0] PAT = 8'b1000_1000;  // D,D,D,I,D,D,D,I
`endif

  initial begin
    mem[32'h1c00_0000] = 32'h1111_0000;
    mem[32'h1c00_0004] = 32'h2222_0004;
    mem[32'h1c00_0010] = 32'h3333_0010;
    mem[32'h0000_0100] = 32'haaaa_0100;
    mem[32'h0000_0200] = 32'h5566_7788;

    // ---- reset with both requests valid
    idle;
    reset = 1'b1;
    inst_req_valid = 1'b1; inst_req_addr = 32'h1c00_0000;
    data_req_valid = 1'b1; data_req_addr = 32'h100;
    settle;
    chk("rst_ram_en", ram_en, 1'b0);
    chk("rst_iready", inst_req_ready, 1'b0);
    chk("rst_dready", data_req_ready, 1'b0);
    chk("rst_irsp", inst_rsp_valid, 1'b0);
    chk("rst_drsp", data_rsp_valid, 1'b0);
    tick;
    settle;
    chk("rst2_ram_en", ram_en, 1'b0);

    // ---- first cycle after reset: data wins
    tick; reset = 1'b0;
    settle;
    chk("post_rst_dready", data_req_ready, 1'b1);
    chk("post_rst_iready", inst_req_ready, 1'b0);
    chk("post_rst_addr", ram_addr, 32'h100);
    chk("post_rst_ram_en", ram_en, 1'b1);

    // ---- load returns while the fetch is granted
    tick; data_req_valid = 1'b0;
    settle;
    chk("ld_rsp_valid", data_rsp_valid, 1'b1);
    chk("ld_rsp_data", data_rsp_data, 32'haaaa_0100);
    chk("if0_iready", inst_req_ready, 1'b1);
    chk("if0_addr", ram_addr, 32'h1c00_0000);
    chk("if0_wen", ram_w_en, 4'b0000);

    // ---- back-to-back fetches
    tick; inst_req_addr = 32'h1c00_0004;
    settle;
    chk("if1_iready", inst_req_ready, 1'b1);
    chk("if0_rsp_valid", inst_rsp_valid, 1'b1);
    chk("if0_rsp_data", inst_rsp_data, 32'h1111_0000);
    chk("if_no_drsp", data_rsp_valid, 1'b0);
    chk("if_drsp_data0", data_rsp_data, 32'h0);

    tick; inst_req_valid = 1'b0;
    settle;
    chk("if1_rsp_valid", inst_rsp_valid, 1'b1);
    chk("if1_rsp_data", inst_rsp_data, 32'h2222_0004);
    chk("idle_ram_en", ram_en, 1'b0);
    chk("idle_ram_addr", ram_addr, 32'h0);

    // ---- continuous contention
    for (int i = 0; i < 8; i++) begin
      tick;
      if (i == 0) begin
        inst_req_valid = 1'b1; inst_req_addr = 32'h1c00_0000;
        data_req_valid = 1'b1; data_req_addr = 32'h100;
      end
      settle;
      chk($sformatf("arb%0d_iready", i), inst_req_ready, PAT[i]);
      chk($sformatf("arb%0d_dready", i), data_req_ready, !PAT[i]);
    end
    tick; idle;
    settle;
    chk("arb_last_irsp", inst_rsp_valid, 1'b1);
    chk("arb_last_idata", inst_rsp_data, 32'h1111_0000);
    chk("arb_last_drsp", data_rsp_valid, 1'b0);

    // ---- cancel in the response cycle; data read in the same cycle
    tick; inst_req_valid = 1'b1; inst_req_addr = 32'h1c00_0010;
    settle;
    chk("cx_iready", inst_req_ready, 1'b1);
    tick; idle; inst_cancel = 1'b1;
    data_req_valid = 1'b1; data_req_addr = 32'h200;
    settle;
    chk("cx_irsp", inst_rsp_valid, 1'b0);
    chk("cx_idata", inst_rsp_data, 32'h0);
    chk("cx_dready", data_req_ready, 1'b1);
    tick; idle;
    settle;
    chk("cx_drsp", data_rsp_valid, 1'b1);
    chk("cx_ddata", data_rsp_data, 32'h5566_7788);
    chk("cx_irsp2", inst_rsp_valid, 1'b0);

    // ---- cancel in the grant cycle: RAM read still occurs, no response
    tick; inst_req_valid = 1'b1; inst_req_addr = 32'h1c00_0010; inst_cancel = 1'b1;
    settle;
    chk("cg_iready", inst_req_ready, 1'b1);
    chk("cg_ram_en", ram_en, 1'b1);
    tick; idle;
    settle;
    chk("cg_irsp", inst_rsp_valid, 1'b0);

    // ---- partial store then load of the same word
    tick; data_req_valid = 1'b1; data_req_w_en = 4'b0011;
    data_req_addr = 32'h200; data_req_w_data = 32'hdead_beef;
    settle;
    chk("st_dready", data_req_ready, 1'b1);
    chk("st_wen", ram_w_en, 4'b0011);
    chk("st_wdata", ram_w_data, 32'hdead_beef);
    tick; data_req_w_en = 4'b0000; data_req_w_data = '0;
    settle;
    chk("st_no_rsp", data_rsp_valid, 1'b0);
    chk("ld2_wen", ram_w_en, 4'b0000);
    tick; idle;
    settle;
    chk("ld2_rsp", data_rsp_valid, 1'b1);
    chk("ld2_data", data_rsp_data, 32'h5566_beef);

    // ---- reset with a fetch response in flight
    tick; inst_req_valid = 1'b1; inst_req_addr = 32'h1c00_0000;
    settle;
    chk("rf_iready", inst_req_ready, 1'b1);
    tick; idle; reset = 1'b1;
    settle;
    chk("rf_rsp_in_rst", inst_rsp_valid, 1'b0);
    chk("rf_data_in_rst", inst_rsp_data, 32'h0);
    tick; reset = 1'b0;
    settle;
    chk("rf_rsp_after", inst_rsp_valid, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
